// File: rtl/sdram_wr_fifo_ctrl_if.sv
// Bus bundle between the user/write stage (master) and sdram_wr_fifo_ctrl (slave).
// Defining WR_FIFO_OVF_FLAG_EN adds the sticky overflow flag wr_fifo_ovf.
interface sdram_wr_fifo_ctrl_if #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 24,
    parameter int FIFO_AW = 10,
    parameter int BL_W    = 10
);
    logic                init_end;
    logic                wr_fifo_wr_en;
    logic [DATA_W-1:0]   wr_fifo_wr_data;
    logic [ADDR_W-1:0]   wr_b_addr;
    logic [ADDR_W-1:0]   wr_e_addr;
    logic [BL_W-1:0]     wr_burst_len;
    logic                wr_addr_rst;
    logic                wr_ack;
    logic                wr_end;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [FIFO_AW:0]    wr_fifo_num;
    logic                wr_fifo_full;
`ifdef WR_FIFO_OVF_FLAG_EN
    logic                wr_fifo_ovf;
`endif

    modport master (
        output init_end, wr_fifo_wr_en, wr_fifo_wr_data, wr_b_addr, wr_e_addr,
               wr_burst_len, wr_addr_rst, wr_ack, wr_end,
`ifdef WR_FIFO_OVF_FLAG_EN
        input  wr_fifo_ovf,
`endif
        input  wr_en, wr_addr, wr_data, wr_fifo_num, wr_fifo_full
    );

    modport slave (
        input  init_end, wr_fifo_wr_en, wr_fifo_wr_data, wr_b_addr, wr_e_addr,
               wr_burst_len, wr_addr_rst, wr_ack, wr_end,
`ifdef WR_FIFO_OVF_FLAG_EN
        output wr_fifo_ovf,
`endif
        output wr_en, wr_addr, wr_data, wr_fifo_num, wr_fifo_full
    );
endinterface

// File: rtl/sdram_wr_fifo_ctrl.sv
// SDRAM write feeder: single-clock FIFO plus burst request FSM and burst address generator.
// Optional WR_FIFO_OVF_FLAG_EN adds a sticky flag for pushes dropped while full.
module sdram_wr_fifo_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 24,
    parameter int FIFO_AW = 10,
    parameter int BL_W    = 10
) (
    input  logic                wr_clk,
    input  logic                wr_rst,
    sdram_wr_fifo_ctrl_if.slave bus
);
    localparam int NUM_W = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [NUM_W-1:0]   NUM_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [NUM_W-1:0]   NUM_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [NUM_W-1:0]    r_num;
    logic                r_full;
    logic [DATA_W-1:0]   r_wr_data;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_load_pend;

    logic                w_push;
    logic                w_pop;
    logic [NUM_W-1:0]    w_num_nxt;
    logic [NUM_W-1:0]    w_bl_num;
    logic [ADDR_W-1:0]   w_bl_addr;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [ADDR_W:0]     w_addr_end;
    logic                w_addr_wrap;

    assign w_push    = bus.wr_fifo_wr_en && !r_full;
    assign w_pop     = bus.wr_ack && (r_num != {NUM_W{1'b0}});
    assign w_bl_num  = NUM_W'(bus.wr_burst_len);
    assign w_bl_addr = ADDR_W'(bus.wr_burst_len);

    // Next burst would run past the exclusive end address: wrap to base.
    assign w_addr_inc  = r_wr_addr + w_bl_addr;
    assign w_addr_end  = {1'b0, w_addr_inc} + {1'b0, w_bl_addr};
    assign w_addr_wrap = (w_addr_end > {1'b0, bus.wr_e_addr});

    // Fill-level next value
    always_comb begin
        w_num_nxt = r_num;
        if (w_push && !w_pop) begin
            w_num_nxt = r_num + NUM_ONE;
        end else if (!w_push && w_pop) begin
            w_num_nxt = r_num - NUM_ONE;
        end else begin
            w_num_nxt = r_num;
        end
    end

    // FIFO storage array (no reset, contents qualified by the pointers)
    always_ff @(posedge wr_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_fifo_wr_data;
        end
    end

    // FIFO pointers, fill level, full flag and registered read data
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_wr_ptr  <= {FIFO_AW{1'b0}};
            r_rd_ptr  <= {FIFO_AW{1'b0}};
            r_num     <= {NUM_W{1'b0}};
            r_full    <= 1'b0;
            r_wr_data <= {DATA_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                r_wr_data <= r_mem[r_rd_ptr];
            end
            r_num  <= w_num_nxt;
            r_full <= (w_num_nxt == NUM_FULL);
        end
    end

    // FSM state register
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.init_end && (r_num >= w_bl_num) && !r_load_pend) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.wr_ack) begin
                    w_state_nxt = S_BURST;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_BURST: begin
                if (bus.wr_end) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_BURST;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Burst address and pending base reload; the address only moves in IDLE or DONE
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_wr_addr   <= {ADDR_W{1'b0}};
            r_load_pend <= 1'b1;
        end else if ((r_state == S_IDLE) && r_load_pend) begin
            r_wr_addr   <= bus.wr_b_addr;
            r_load_pend <= bus.wr_addr_rst;
        end else if (r_state == S_DONE) begin
            r_load_pend <= bus.wr_addr_rst;
            if (r_load_pend || w_addr_wrap) begin
                r_wr_addr <= bus.wr_b_addr;
            end else begin
                r_wr_addr <= w_addr_inc;
            end
        end else if (bus.wr_addr_rst) begin
            r_load_pend <= 1'b1;
        end
    end

`ifdef WR_FIFO_OVF_FLAG_EN
    logic r_ovf;

    // Sticky overflow flag; the reload request clears it with priority
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_ovf <= 1'b0;
        end else if (bus.wr_addr_rst) begin
            r_ovf <= 1'b0;
        end else if (bus.wr_fifo_wr_en && r_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.wr_fifo_ovf = r_ovf;
`endif

    assign bus.wr_en        = (r_state == S_REQ);
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.wr_fifo_num  = r_num;
    assign bus.wr_fifo_full = r_full;
endmodule

// File: tb/tb_sdram_wr_fifo_ctrl.sv
// Self-checking bench for sdram_wr_fifo_ctrl: directed scenarios plus randomized bursts
// checked against a queue-based FIFO model and an arithmetic address model.
module tb_sdram_wr_fifo_ctrl;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 24;
    localparam int FIFO_AW = 10;
    localparam int BL_W    = 10;
    localparam int DEPTH   = 1024;

    logic wr_clk = 1'b0;
    logic wr_rst;

    always #5 wr_clk = ~wr_clk;

    sdram_wr_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_AW(FIFO_AW), .BL_W(BL_W)) bus ();

    sdram_wr_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_AW(FIFO_AW), .BL_W(BL_W)) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] q_model[$];
    longint m_addr;
    longint m_b;
    longint m_e;
    bit     m_load_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic push_words(input int n, input int base, input bit rnd);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? DATA_W'($urandom) : DATA_W'(base + i);
            bus.wr_fifo_wr_en   = 1'b1;
            bus.wr_fifo_wr_data = d;
            tick();
            if (q_model.size() < DEPTH) q_model.push_back(d);
            chk("fifo_num", 32'(bus.wr_fifo_num), 32'(q_model.size()));
        end
        bus.wr_fifo_wr_en = 1'b0;
    endtask

    task automatic reload_base(input longint b, input longint e);
        bus.wr_b_addr   = ADDR_W'(b);
        bus.wr_e_addr   = ADDR_W'(e);
        m_b = b;
        m_e = e;
        bus.wr_addr_rst = 1'b1;
        tick();
        bus.wr_addr_rst = 1'b0;
        tick();
        m_addr = m_b;
        chk("reload_addr", 32'(bus.wr_addr), 32'(m_addr));
    endtask

    // Write-stage model: wait for request, 3-cycle ACT/TRCD, bl acks, wr_end pulse.
    task automatic run_burst(input int bl, input int reload_at);
        int waited;
        logic [DATA_W-1:0] exp_d;
        longint nxt;
        waited = 0;
        exp_d = '0;
        while (bus.wr_en !== 1'b1 && waited < 2000) begin
            tick();
            waited++;
        end
        chk("req_timeout", 32'(waited < 2000), 32'd1);
        if (waited >= 2000) return;
        chk("burst_addr", 32'(bus.wr_addr), 32'(m_addr));
        repeat (3) begin
            tick();
            chk("wr_en_hold", 32'(bus.wr_en), 32'd1);
        end
        for (int i = 0; i < bl; i++) begin
            bus.wr_ack      = 1'b1;
            bus.wr_addr_rst = (i == reload_at);
            tick();
            if (i == reload_at) m_load_pend = 1'b1;
            if (q_model.size() > 0) exp_d = q_model.pop_front();
            chk("wr_data", 32'(bus.wr_data), 32'(exp_d));
            chk("wr_en_low", 32'(bus.wr_en), 32'd0);
            chk("addr_stable", 32'(bus.wr_addr), 32'(m_addr));
        end
        bus.wr_ack      = 1'b0;
        bus.wr_addr_rst = 1'b0;
        bus.wr_end      = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        chk("done_addr", 32'(bus.wr_addr), 32'(m_addr));
        tick();
        nxt = (m_addr + longint'(bl)) % (longint'(1) << ADDR_W);
        if (m_load_pend || (nxt + longint'(bl) > m_e)) m_addr = m_b;
        else m_addr = nxt;
        m_load_pend = 1'b0;
        chk("next_addr", 32'(bus.wr_addr), 32'(m_addr));
        chk("data_hold", 32'(bus.wr_data), 32'(exp_d));
        chk("num_after", 32'(bus.wr_fifo_num), 32'(q_model.size()));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bl;
        int waited;
        wr_rst              = 1'b1;
        bus.init_end        = 1'b1;
        bus.wr_fifo_wr_en   = 1'b0;
        bus.wr_fifo_wr_data = '0;
        bus.wr_b_addr       = 24'h000100;
        bus.wr_e_addr       = 24'h001000;
        bus.wr_burst_len    = 10'd10;
        bus.wr_addr_rst     = 1'b0;
        bus.wr_ack          = 1'b0;
        bus.wr_end          = 1'b0;
        m_b = 64'h100;
        m_e = 64'h1000;
        m_load_pend = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_num", 32'(bus.wr_fifo_num), 32'd0);
        chk("rst_full", 32'(bus.wr_fifo_full), 32'd0);

        // Reset release loads the base address on the first clock
        wr_rst = 1'b0;
        tick();
        m_addr = m_b;
        chk("rel_addr", 32'(bus.wr_addr), 32'h000100);
        push_words(9, 0, 1'b0);
        chk("nine_no_req", 32'(bus.wr_en), 32'd0);
        push_words(1, 9, 1'b0);
        chk("ten_no_req_yet", 32'(bus.wr_en), 32'd0);
        tick();
        chk("req_latency", 32'(bus.wr_en), 32'd1);
        run_burst(10, -1);
        chk("first_next_addr", 32'(bus.wr_addr), 32'h00010A);
        chk("first_num", 32'(bus.wr_fifo_num), 32'd0);

        // Wrap-around: 0, 10, 20, then back to 0
        reload_base(0, 30);
        push_words(30, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("wrap_seq_addr", 32'(bus.wr_addr), 32'(k * 10));
            run_burst(10, -1);
        end
        chk("wrap_final", 32'(bus.wr_addr), 32'd0);

        // Overflow with no acks, then drain in four bursts of 256
        bus.wr_burst_len = 10'd256;
        bus.wr_e_addr    = 24'h100000;
        m_e = 64'h100000;
        push_words(1030, 0, 1'b1);
        chk("ovf_num", 32'(bus.wr_fifo_num), 32'd1024);
        chk("ovf_full", 32'(bus.wr_fifo_full), 32'd1);
`ifdef WR_FIFO_OVF_FLAG_EN
        chk("ovf_flag_set", 32'(bus.wr_fifo_ovf), 32'd1);
        tick();
        chk("ovf_flag_sticky", 32'(bus.wr_fifo_ovf), 32'd1);
`endif
        bus.wr_addr_rst = 1'b1;
        tick();
        bus.wr_addr_rst = 1'b0;
        m_load_pend = 1'b1;
`ifdef WR_FIFO_OVF_FLAG_EN
        chk("ovf_flag_clr", 32'(bus.wr_fifo_ovf), 32'd0);
`endif
        for (int k = 0; k < 4; k++) run_burst(256, -1);
        chk("drain_num", 32'(bus.wr_fifo_num), 32'd0);
        chk("drain_full", 32'(bus.wr_fifo_full), 32'd0);

        // Mid-burst reload: address held until DONE, then the new base
        bus.wr_burst_len = 10'd8;
        reload_base(64'h200, 64'h100000);
        bus.wr_b_addr = 24'h000300;
        m_b = 64'h300;
        push_words(8, 0, 1'b1);
        run_burst(8, 2);
        chk("midreload_addr", 32'(bus.wr_addr), 32'h000300);

        // Randomized regions, burst lengths and fill amounts
        for (int it = 0; it < 6; it++) begin
            longint b;
            b = longint'($urandom_range(0, 4000));
            reload_base(b, b + longint'($urandom_range(1, 80)));
            bl = $urandom_range(1, 20);
            bus.wr_burst_len = BL_W'(bl);
            push_words($urandom_range(0, 45), 0, 1'b1);
            while (q_model.size() >= bl) begin
                run_burst(bl, ($urandom_range(0, 3) == 0) ? $urandom_range(0, bl - 1) : -1);
            end
        end

        // Async reset in the middle of a burst
        bus.wr_burst_len = 10'd8;
        bl = 8;
        push_words(8, 0, 1'b1);
        waited = 0;
        while (bus.wr_en !== 1'b1 && waited < 2000) begin
            tick();
            waited++;
        end
        chk("arst_req_timeout", 32'(waited < 2000), 32'd1);
        bus.wr_ack = 1'b1;
        repeat (3) tick();
        bus.wr_ack = 1'b0;
        #2;
        wr_rst = 1'b1;
        #1;
        chk("arst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("arst_num", 32'(bus.wr_fifo_num), 32'd0);
        chk("arst_full", 32'(bus.wr_fifo_full), 32'd0);
        chk("arst_data", 32'(bus.wr_data), 32'd0);
        chk("arst_addr", 32'(bus.wr_addr), 32'd0);
        q_model.delete();
        tick();
        wr_rst = 1'b0;
        tick();
        chk("arst_reload", 32'(bus.wr_addr), 32'(m_b));
        chk("arst_idle", 32'(bus.wr_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
